pipelined_rca_adder: RTL
========================

// Module: pipelined_rca_adder
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor for the datapath library.
//  WIDTH-bit operands are split into SEG-bit segments. Each pipeline stage ripples one segment.
//  The carry is registered between stages, so throughput is one operation per clock.
//  A valid/ready handshake on input and output lets the block sit between stalling producer/consumer.
// PARAMETERS
//  WIDTH   32  operand/result width in bits
//  SEG     8   bits rippled per stage; STAGES = WIDTH/SEG; WIDTH%SEG!=0 -> elaboration error
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      a/b/cin/sub valid this cycle
//  in_ready   out  1      block can accept; transfer when in_valid & in_ready at clk edge
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in (add mode only)
//  sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
//  out_valid  out  1      sum/cout/ovf hold a completed result
//  out_ready  in   1      consumer accepts; result leaves when out_valid & out_ready
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of MSB (sub mode: 1 = no borrow)
//  ovf        out  1      two's-complement overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//  - One clock, synchronous active-high reset. No other clock or async path.
//  - Reset: every stage valid bit = 0; out_valid=0; sum=0, cout=0, ovf=0; in_ready=1 next cycle.
//  - Stage 0 (input edge): capture b' = sub ? ~b : b and c0 = sub ? 1 : cin.
//    Ripple segment 0 combinationally from the inputs; register seg0 sum and carry.
//    Operand bits not yet used are carried forward in skew registers.
//  - Stage k (1..STAGES-1): ripple segment k using the registered carry from stage k-1.
//    Already-computed low sum bits pass through unchanged.
//  - Last stage register drives sum/cout/ovf directly (registered outputs, no comb path a->sum).
//    ovf is computed in the last stage from the MSB carry-in and carry-out.
//  - Latency: operand transferred at edge N -> out_valid=1 with its result after edge N+STAGES-1.
//    Example: STAGES=4 gives 4 cycles.
//  - Throughput: one transfer per cycle while out_ready=1. Results emerge in issue order.
//  - Stall: stall = out_valid & ~out_ready.
//    While stalled, every stage register and valid bit holds and in_ready=0.
//    Bubbles are not compressed, which keeps a simple global enable.
//  - in_ready = ~stall (combinational from out_valid/out_ready only; no dependence on in_valid).
//  - in_valid=0 while not stalled inserts a bubble (valid bit 0). Data regs may update; don't care.
//  - Outputs hold stable while out_valid=1 and out_ready=0.
//  - Reset mid-operation: all in-flight results are discarded. Nothing emerges after reset deasserts.
//  - Simultaneous reset and in_valid: reset wins; the operand is not accepted.
//  - STAGES=1 is legal: a full-width registered adder with latency 1.
// TESTING (WIDTH=32, SEG=8 unless stated)
//  1 a=0x00000000 b=0x00000001 cin=0 sub=0 -> after 4 cycles sum=0x00000001 cout=0 ovf=0
//  2 a=0xDABC9875 b=0xEFBC9615 cin=0 sub=0 -> sum=0xCA792E8A cout=1 ovf=0
//  3 a=0xFFFFFFFF b=0x00000000 cin=1 (carry ripples through all stages) -> sum=0x00000000 cout=1 ovf=0
//  4 a=0x80000000 b=0x00000001 sub=1 -> sum=0x7FFFFFFF cout=1 ovf=1; a=5 b=7 sub=1 -> 0xFFFFFFFE cout=0 ovf=0
//  5 Back-to-back stream of 6 adds, out_ready=0 for 3 cycles mid-stream.
//    -> in_ready=0 during the stall; all 6 results correct, in order, none lost or duplicated.
//  6 Two ops in flight, reset pulsed 1 cycle.
//    -> out_valid=0 the cycle after; neither result ever appears; a new op 5 cycles later completes normally.
//  Also rerun 1-5 with WIDTH=16 SEG=4 and WIDTH=8 SEG=8 against a behavioural a+b model.

Source files
------------

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment is rippled per stage,
// with the segment carry and unused operand bits registered between stages.
module pipelined_rca_adder #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / SEG;

   generate
      if (WIDTH % SEG != 0) begin : g_bad_seg
         $error("pipelined_rca_adder: WIDTH must be a multiple of SEG");
      end
   endgenerate

   // Handshake: a transfer happens at a clock edge where valid & ready are both high.
   // The whole pipe shares one enable; it freezes only while a finished result waits.
   logic stall;

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] carry_q, carry_d;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic              ovf_q, ovf_d;

   logic [WIDTH-1:0]  a_src [STAGES];
   logic [WIDTH-1:0]  b_src [STAGES];
   logic [WIDTH-1:0]  s_src [STAGES];
   logic [STAGES-1:0] c_src;
   logic [STAGES-1:0] v_src;
   logic [SEG:0]      seg_res;
   logic              msb_cin;

   always_comb begin
      // Stage 0 works on the raw inputs; subtraction becomes a + ~b + 1.
      a_src[0] = a;
      b_src[0] = sub ? ~b : b;
      s_src[0] = '0;
      c_src    = '0;
      v_src    = '0;
      c_src[0] = sub ? 1'b1 : cin;
      v_src[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         a_src[k] = a_q[k-1];
         b_src[k] = b_q[k-1];
         s_src[k] = sum_q[k-1];
         c_src[k] = carry_q[k-1];
         v_src[k] = valid_q[k-1];
      end

      seg_res = '0;
      valid_d = '0;
      carry_d = '0;
      for (int k = 0; k < STAGES; k++) begin
         seg_res = {1'b0, a_src[k][k*SEG +: SEG]} + {1'b0, b_src[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_src[k]};
         a_d[k]                 = a_src[k];
         b_d[k]                 = b_src[k];
         sum_d[k]               = s_src[k];
         sum_d[k][k*SEG +: SEG] = seg_res[SEG-1:0];
         carry_d[k]             = seg_res[SEG];
         valid_d[k]             = v_src[k];
      end

      // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
      msb_cin = sum_d[STAGES-1][WIDTH-1] ^ a_src[STAGES-1][WIDTH-1] ^ b_src[STAGES-1][WIDTH-1];
      ovf_d   = msb_cin ^ carry_d[STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else if (!stall) begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

   assign stall     = valid_q[STAGES-1] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = valid_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule
